// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// One request is outstanding at a time; responses come back in order.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// IF stage with IF/ID holding register: single-outstanding instruction fetch,
// one-entry skid buffer and MIPS one-instruction delay-slot redirect handling.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] id_jumpreq,
    input  logic        id_stallreq,
    if_fetch_if.master  imem,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        if_in_delayslot_o
);
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fpc, fpc_n, req_pc, req_pc_n, tgt, tgt_n;
    logic [31:0] skid_pc, skid_pc_n, skid_inst, skid_inst_n;
    logic        jmp_pend, jmp_pend_n, ds_next, ds_next_n, skid_ds, skid_ds_n;
    logic [31:0] pc_n, inst_n;
    logic        valid_n, ds_n;
    logic        cons, can_load, jump_take, accept, load_mem, to_skid, load_skid;
    logic [31:0] jump_addr;

    assign cons      = if_valid_o & ~id_stallreq;
    assign can_load  = ~if_valid_o | cons;
    assign jump_take = cons & id_jumpreq[32];
    assign jump_addr = {id_jumpreq[31:2], 2'b00};

    assign imem.imem_req  = (state == REQ) & can_load;
    assign imem.imem_addr = fpc;
    assign accept         = imem.imem_req & imem.imem_ready;

    assign load_mem  = (state == WAIT) & imem.imem_rvalid & can_load;
    assign to_skid   = (state == WAIT) & imem.imem_rvalid & ~can_load;
    assign load_skid = (state == HOLD) & can_load;

    always_comb begin
        state_n     = state;
        fpc_n       = fpc;
        req_pc_n    = req_pc;
        tgt_n       = tgt;
        jmp_pend_n  = jmp_pend;
        ds_next_n   = ds_next;
        skid_pc_n   = skid_pc;
        skid_inst_n = skid_inst;
        skid_ds_n   = skid_ds;
        pc_n        = if_pc_o;
        inst_n      = if_inst_o;
        valid_n     = if_valid_o;
        ds_n        = if_in_delayslot_o;

        case (state)
            IDLE:    state_n = REQ;
            REQ:     if (accept) state_n = WAIT;
            WAIT:    if (load_mem) state_n = REQ;
                     else if (to_skid) state_n = HOLD;
            HOLD:    if (load_skid) state_n = REQ;
            default: state_n = IDLE;
        endcase

        if (accept) begin
            req_pc_n   = fpc;
            fpc_n      = jmp_pend ? tgt : fpc + 32'd4;
            jmp_pend_n = 1'b0;
        end

        // A jump sees fpc after this cycle's acceptance: B+4 still unrequested
        // defers the redirect, otherwise the delay slot is already in flight.
        if (jump_take) begin
            if (fpc_n == if_pc_o + 32'd4) begin
                jmp_pend_n = 1'b1;
                tgt_n      = jump_addr;
            end else begin
                fpc_n = jump_addr;
            end
        end

        if (load_mem) begin
            pc_n      = req_pc;
            inst_n    = imem.imem_rdata;
            valid_n   = 1'b1;
            ds_n      = ds_next | jump_take;
            ds_next_n = 1'b0;
        end else if (to_skid) begin
            skid_pc_n   = req_pc;
            skid_inst_n = imem.imem_rdata;
            skid_ds_n   = ds_next;
            ds_next_n   = 1'b0;
        end else if (load_skid) begin
            pc_n    = skid_pc;
            inst_n  = skid_inst;
            valid_n = 1'b1;
            ds_n    = skid_ds | jump_take;
        end else if (cons) begin
            valid_n = 1'b0;
            inst_n  = 32'h0;
            ds_n    = 1'b0;
        end

        // The instruction loaded alongside a consumed jump is its delay slot.
        if (jump_take && !load_mem && !load_skid) begin
            ds_next_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state             <= IDLE;
            fpc               <= RESET_PC;
            req_pc            <= 32'h0;
            tgt               <= 32'h0;
            jmp_pend          <= 1'b0;
            ds_next           <= 1'b0;
            skid_pc           <= 32'h0;
            skid_inst         <= 32'h0;
            skid_ds           <= 1'b0;
            if_pc_o           <= 32'h0;
            if_inst_o         <= 32'h0;
            if_valid_o        <= 1'b0;
            if_in_delayslot_o <= 1'b0;
        end else begin
            state             <= state_n;
            fpc               <= fpc_n;
            req_pc            <= req_pc_n;
            tgt               <= tgt_n;
            jmp_pend          <= jmp_pend_n;
            ds_next           <= ds_next_n;
            skid_pc           <= skid_pc_n;
            skid_inst         <= skid_inst_n;
            skid_ds           <= skid_ds_n;
            if_pc_o           <= pc_n;
            if_inst_o         <= inst_n;
            if_valid_o        <= valid_n;
            if_in_delayslot_o <= ds_n;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: an in-order instruction memory with selectable
// latency answers every fetch with a word derived from its address.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] id_jumpreq;
    logic        id_stallreq;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        if_in_delayslot_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    logic [31:0] acc_log [0:63];
    int          acc_n;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          mc;
    logic [31:0] ma;
    logic        mem_acc;

    if_fetch_if imem_bus ();

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_jumpreq        (id_jumpreq),
        .id_stallreq       (id_stallreq),
        .imem              (imem_bus),
        .if_pc_o           (if_pc_o),
        .if_inst_o         (if_inst_o),
        .if_valid_o        (if_valid_o),
        .if_in_delayslot_o (if_in_delayslot_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: mem_lat=1 puts rvalid in the cycle right after acceptance.
    assign mem_acc = imem_bus.imem_req & imem_bus.imem_ready;

    always_comb begin
        mc = mem_acc ? mem_lat : pend_cnt;
        ma = mem_acc ? imem_bus.imem_addr : pend_addr;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_bus.imem_rvalid <= 1'b0;
            imem_bus.imem_rdata  <= 32'h0;
            pend_cnt             <= 0;
            pend_addr            <= 32'h0;
            acc_n                <= 0;
        end else begin
            if (mem_acc) begin
                if (acc_n < 64) acc_log[acc_n] <= imem_bus.imem_addr;
                acc_n <= acc_n + 1;
            end
            imem_bus.imem_rvalid <= (mc == 1);
            if (mc == 1) imem_bus.imem_rdata <= inst_of(ma);
            pend_cnt  <= (mc > 1) ? mc - 1 : 0;
            pend_addr <= ma;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        id_stallreq = 1'b0;
        id_jumpreq = '0;
        imem_bus.imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_for_pc(input logic [31:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (if_valid_o === 1'b1 && if_pc_o === target) ok = 1'b1;
        end
    endtask

    task automatic next_delivery(output logic [31:0] pc, output logic [31:0] inst,
                                 output logic ds);
        bit found = 1'b0;
        pc = 'x;
        inst = 'x;
        ds = 1'bx;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (if_valid_o === 1'b1) begin
                found = 1'b1;
                pc = if_pc_o;
                inst = if_inst_o;
                ds = if_in_delayslot_o;
            end
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        id_stallreq = 1'b0;
        id_jumpreq = '0;
        imem_bus.imem_ready = 1'b1;
        mem_lat = 1;
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_valid: got %b want 0", if_valid_o); end
        n_cmp++; if (if_inst_o !== 32'h0) begin n_err++; $display("[TB] FAIL rst_inst: got %h want 0", if_inst_o); end
        n_cmp++; if (if_pc_o !== 32'h0) begin n_err++; $display("[TB] FAIL rst_pc: got %h want 0", if_pc_o); end
        n_cmp++; if (if_in_delayslot_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_ds: got %b want 0", if_in_delayslot_o); end
        n_cmp++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL rst_req: got %b want 0", imem_bus.imem_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        // Release cycle is IDLE; the first request appears one cycle later.
        n_cmp++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL idle_req: got %b want 0", imem_bus.imem_req); end
        @(negedge clk);
        n_cmp++; if (imem_bus.imem_req !== 1'b1) begin n_err++; $display("[TB] FAIL first_req: got %b want 1", imem_bus.imem_req); end
        n_cmp++; if (imem_bus.imem_addr !== RESET_PC) begin n_err++; $display("[TB] FAIL first_addr: got %h want %h", imem_bus.imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] ep;
        $display("[TB] test_sequential");
        mem_lat = 1;
        do_reset();
        for (int c = 2; c <= 15; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                ep = 32'(4 * ((c - 2) / 2));
                n_cmp++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== ep) begin n_err++; $display("[TB] FAIL seq_req c%0d: got %b/%h want 1/%h", c, imem_bus.imem_req, imem_bus.imem_addr, ep); end
            end else begin
                n_cmp++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL seq_noreq c%0d: got %b want 0", c, imem_bus.imem_req); end
            end
            if (c >= 4 && c % 2 == 0) begin
                ep = 32'(4 * ((c - 4) / 2));
                n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== ep) begin n_err++; $display("[TB] FAIL seq_pc c%0d: got %b/%h want 1/%h", c, if_valid_o, if_pc_o, ep); end
                n_cmp++; if (if_inst_o !== inst_of(ep)) begin n_err++; $display("[TB] FAIL seq_inst c%0d: got %h want %h", c, if_inst_o, inst_of(ep)); end
                n_cmp++; if (if_in_delayslot_o !== 1'b0) begin n_err++; $display("[TB] FAIL seq_ds c%0d: got %b want 0", c, if_in_delayslot_o); end
            end else begin
                n_cmp++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin n_err++; $display("[TB] FAIL seq_bubble c%0d: got %b/%h want 0/0", c, if_valid_o, if_inst_o); end
            end
        end
    endtask

    task automatic test_jump_case_a();
        bit ok;
        int base;
        logic [31:0] p, n;
        logic d;
        logic [31:0] exp_pc [0:2];
        logic exp_ds [0:2];
        $display("[TB] test_jump_case_a");
        exp_pc = '{32'h14, 32'h40, 32'h44};
        exp_ds = '{1'b1, 1'b0, 1'b0};
        mem_lat = 1;
        do_reset();
        wait_for_pc(32'h10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL a_reach: got timeout want pc 00000010"); end
        base = acc_n;
        // Memory stalls the B+4 request so the jump finds it not yet requested.
        id_jumpreq = {1'b1, 32'h0000_0040};
        imem_bus.imem_ready = 1'b0;
        @(negedge clk);
        id_jumpreq = '0;
        imem_bus.imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_delivery(p, n, d);
            n_cmp++; if (p !== exp_pc[i]) begin n_err++; $display("[TB] FAIL a_pc%0d: got %h want %h", i, p, exp_pc[i]); end
            n_cmp++; if (n !== inst_of(exp_pc[i])) begin n_err++; $display("[TB] FAIL a_inst%0d: got %h want %h", i, n, inst_of(exp_pc[i])); end
            n_cmp++; if (d !== exp_ds[i]) begin n_err++; $display("[TB] FAIL a_ds%0d: got %b want %b", i, d, exp_ds[i]); end
        end
        n_cmp++; if (acc_log[base] !== 32'h14) begin n_err++; $display("[TB] FAIL a_acc0: got %h want 00000014", acc_log[base]); end
        n_cmp++; if (acc_log[base + 1] !== 32'h40) begin n_err++; $display("[TB] FAIL a_acc1: got %h want 00000040", acc_log[base + 1]); end
    endtask

    task automatic test_jump_case_b();
        bit ok;
        int base;
        logic [31:0] p, n;
        logic d;
        $display("[TB] test_jump_case_b");
        mem_lat = 3;
        do_reset();
        wait_for_pc(32'h10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL b_reach: got timeout want pc 00000010"); end
        base = acc_n;
        // Unaligned target: low bits must be dropped.
        id_jumpreq = {1'b1, 32'h0000_0043};
        @(negedge clk);
        id_jumpreq = '0;
        n_cmp++; if (imem_bus.imem_addr !== 32'h40) begin n_err++; $display("[TB] FAIL b_fpc: got %h want 00000040", imem_bus.imem_addr); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h14 || n !== inst_of(32'h14)) begin n_err++; $display("[TB] FAIL b_slot: got %h/%h want 00000014/%h", p, n, inst_of(32'h14)); end
        n_cmp++; if (d !== 1'b1) begin n_err++; $display("[TB] FAIL b_slot_ds: got %b want 1", d); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h40 || n !== inst_of(32'h40)) begin n_err++; $display("[TB] FAIL b_tgt: got %h/%h want 00000040/%h", p, n, inst_of(32'h40)); end
        n_cmp++; if (d !== 1'b0) begin n_err++; $display("[TB] FAIL b_tgt_ds: got %b want 0", d); end
        n_cmp++; if (acc_log[base] !== 32'h14 || acc_log[base + 1] !== 32'h40) begin n_err++; $display("[TB] FAIL b_acc: got %h,%h want 00000014,00000040", acc_log[base], acc_log[base + 1]); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] p, n;
        logic d;
        $display("[TB] test_stall");
        mem_lat = 3;
        do_reset();
        wait_for_pc(32'h8, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL st_reach: got timeout want pc 00000008"); end
        @(negedge clk);
        id_stallreq = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL st_req%0d: got %b want 0", i, imem_bus.imem_req); end
            if (i >= 4) begin
                n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC) begin n_err++; $display("[TB] FAIL st_pc%0d: got %b/%h want 1/0000000c", i, if_valid_o, if_pc_o); end
                n_cmp++; if (if_inst_o !== inst_of(32'hC)) begin n_err++; $display("[TB] FAIL st_inst%0d: got %h want %h", i, if_inst_o, inst_of(32'hC)); end
            end
        end
        id_stallreq = 1'b0;
        #1;
        n_cmp++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h10) begin n_err++; $display("[TB] FAIL st_resume: got %b/%h want 1/00000010", imem_bus.imem_req, imem_bus.imem_addr); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h10 || n !== inst_of(32'h10)) begin n_err++; $display("[TB] FAIL st_next: got %h/%h want 00000010/%h", p, n, inst_of(32'h10)); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h14) begin n_err++; $display("[TB] FAIL st_next2: got %h want 00000014", p); end
    endtask

    task automatic test_jump_while_stalled();
        bit ok;
        logic [31:0] p, n;
        logic d;
        logic [31:0] exp_pc [0:2];
        logic exp_ds [0:2];
        $display("[TB] test_jump_while_stalled");
        exp_pc = '{32'hC, 32'h80, 32'h84};
        exp_ds = '{1'b1, 1'b0, 1'b0};
        mem_lat = 1;
        do_reset();
        wait_for_pc(32'h8, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL js_reach: got timeout want pc 00000008"); end
        id_stallreq = 1'b1;
        id_jumpreq = {1'b1, 32'h0000_0080};
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8) begin n_err++; $display("[TB] FAIL js_hold%0d: got %b/%h want 1/00000008", i, if_valid_o, if_pc_o); end
            n_cmp++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'hC) begin n_err++; $display("[TB] FAIL js_fpc%0d: got %b/%h want 0/0000000c", i, imem_bus.imem_req, imem_bus.imem_addr); end
        end
        id_stallreq = 1'b0;
        @(negedge clk);
        id_jumpreq = '0;
        for (int i = 0; i < 3; i++) begin
            next_delivery(p, n, d);
            n_cmp++; if (p !== exp_pc[i] || n !== inst_of(exp_pc[i])) begin n_err++; $display("[TB] FAIL js_pc%0d: got %h/%h want %h/%h", i, p, n, exp_pc[i], inst_of(exp_pc[i])); end
            n_cmp++; if (d !== exp_ds[i]) begin n_err++; $display("[TB] FAIL js_ds%0d: got %b want %b", i, d, exp_ds[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        logic [31:0] p, n;
        logic d;
        $display("[TB] test_reset_midflight");
        mem_lat = 3;
        do_reset();
        wait_for_pc(32'h10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rm_reach: got timeout want pc 00000010"); end
        id_jumpreq = {1'b1, 32'h0000_0040};
        imem_bus.imem_ready = 1'b0;
        @(negedge clk);
        id_jumpreq = '0;
        n_cmp++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h14) begin n_err++; $display("[TB] FAIL rm_pend: got %b/%h want 1/00000014", imem_bus.imem_req, imem_bus.imem_addr); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin n_err++; $display("[TB] FAIL rm_async_pc: got %h/%h want 0/0", if_pc_o, if_inst_o); end
        n_cmp++; if (if_valid_o !== 1'b0 || if_in_delayslot_o !== 1'b0) begin n_err++; $display("[TB] FAIL rm_async_flags: got %b/%b want 0/0", if_valid_o, if_in_delayslot_o); end
        n_cmp++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL rm_async_req: got %b want 0", imem_bus.imem_req); end
        imem_bus.imem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin n_err++; $display("[TB] FAIL rm_first: got %b/%h want 1/%h", imem_bus.imem_req, imem_bus.imem_addr, RESET_PC); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h0 || d !== 1'b0) begin n_err++; $display("[TB] FAIL rm_d0: got %h/%b want 00000000/0", p, d); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h4 || d !== 1'b0) begin n_err++; $display("[TB] FAIL rm_d1: got %h/%b want 00000004/0", p, d); end
    endtask

    task automatic test_wrap();
        // fpc arithmetic wraps at 32 bits: a jump to the top word continues at 0.
        logic [31:0] p, n;
        logic d;
        bit ok;
        $display("[TB] test_wrap");
        mem_lat = 1;
        do_reset();
        wait_for_pc(32'h4, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL w_reach: got timeout want pc 00000004"); end
        id_jumpreq = {1'b1, 32'hFFFF_FFFC};
        @(negedge clk);
        id_jumpreq = '0;
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h8 || d !== 1'b1) begin n_err++; $display("[TB] FAIL w_slot: got %h/%b want 00000008/1", p, d); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'hFFFF_FFFC || n !== inst_of(32'hFFFF_FFFC)) begin n_err++; $display("[TB] FAIL w_top: got %h/%h want fffffffc/%h", p, n, inst_of(32'hFFFF_FFFC)); end
        next_delivery(p, n, d);
        n_cmp++; if (p !== 32'h0) begin n_err++; $display("[TB] FAIL w_zero: got %h want 00000000", p); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_case_a();
        test_jump_case_b();
        test_stall();
        test_jump_while_stalled();
        test_reset_midflight();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
